// File: rtl/sha3_pkg.sv
// ----------------------------------------------------------------------------
// sha3_pkg: shared Keccak state geometry, chi row function, FSM type. rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package sha3_pkg;

  localparam int STATE_ROWS = 5;
  localparam int STATE_COLS = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chi_fsm_e;

  typedef logic [31:0][4:0] inv_tab_t;

  function automatic int lane_base(input int x, input int y, input int lane_w);
    return (x * STATE_ROWS + y) * lane_w;
  endfunction

  function automatic logic [4:0] chi_row(input logic [4:0] a);
    logic [4:0] r;
    for (int x = 0; x < 5; x++) begin
      r[x] = a[x] ^ (~a[(x + 1) % 5] & a[(x + 2) % 5]);
    end
    return r;
  endfunction

  // chi on a 5-bit row is a bijection, so every row value has exactly one preimage.
  function automatic inv_tab_t build_inv_tab();
    inv_tab_t t;
    t = '0;
    for (int r = 0; r < 32; r++) begin
      for (int a = 0; a < 32; a++) begin
        if (chi_row(5'(a)) == 5'(r)) begin
          t[r] = 5'(a);
        end
      end
    end
    return t;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sha3_chi_inv_row.sv
// ----------------------------------------------------------------------------
// sha3_chi_inv_row: combinational inverse of chi on one 5-bit row. rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sha3_chi_inv_row
  import sha3_pkg::*;
(
  input  logic [4:0] row_i,
  output logic [4:0] row_o
);

  localparam inv_tab_t INV_TAB = build_inv_tab();

  assign row_o = INV_TAB[row_i];

endmodule

`default_nettype wire

// File: rtl/sha3_chi_inv.sv
// ----------------------------------------------------------------------------
// sha3_chi_inv: iterative chi inverse, one y-plane per cycle, in place. rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sha3_chi_inv
  import sha3_pkg::*;
#(
  parameter int LANE_W = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [25*LANE_W-1:0]   in_state,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [25*LANE_W-1:0]   out_state,
  output logic                   busy
);

  localparam int STATE_W = 25 * LANE_W;

  chi_fsm_e                             state_q;
  logic [2:0]                           plane_q;
  logic [STATE_W-1:0]                   buf_q;
  logic [STATE_W-1:0]                   buf_d;
  logic                                 out_valid_q;
  logic [STATE_COLS-1:0][LANE_W-1:0]    cur_lane;
  logic [STATE_COLS-1:0][LANE_W-1:0]    inv_lane;

  // Select the five lanes of the active plane.
  always_comb begin
    cur_lane = '0;
    for (int y = 0; y < STATE_ROWS; y++) begin
      for (int x = 0; x < STATE_COLS; x++) begin
        if (plane_q == 3'(y)) begin
          cur_lane[x] = buf_q[lane_base(x, y, LANE_W) +: LANE_W];
        end
      end
    end
  end

  generate
    for (genvar z = 0; z < LANE_W; z++) begin : g_col
      logic [4:0] row_in;
      logic [4:0] row_out;
      for (genvar x = 0; x < STATE_COLS; x++) begin : g_bit
        assign row_in[x]      = cur_lane[x][z];
        assign inv_lane[x][z] = row_out[x];
      end
      sha3_chi_inv_row u_row (
        .row_i (row_in),
        .row_o (row_out)
      );
    end
  endgenerate

  // Write the inverted plane back; all other planes pass through.
  always_comb begin
    buf_d = buf_q;
    for (int y = 0; y < STATE_ROWS; y++) begin
      for (int x = 0; x < STATE_COLS; x++) begin
        if (plane_q == 3'(y)) begin
          buf_d[lane_base(x, y, LANE_W) +: LANE_W] = inv_lane[x];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      plane_q     <= '0;
      buf_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            buf_q   <= in_state;
            plane_q <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          buf_q <= buf_d;
          if (plane_q == 3'd4) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            plane_q <= plane_q + 3'd1;
          end
        end
        DONE: begin
          // Returning to IDLE here keeps the next accept one cycle behind the output handshake.
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_state = buf_q;

endmodule

`default_nettype wire

// File: tb/tb_sha3_chi_inv.sv
// ----------------------------------------------------------------------------
// tb_sha3_chi_inv: directed and round-trip checks of the chi inverse block.
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sha3_chi_inv;

  localparam int LW = 64;
  localparam int SW = 25 * LW;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] in_state;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_state;
  logic          busy;
  logic [4:0]    row_in;
  logic [4:0]    row_out;

  int n_total = 0;
  int n_bad   = 0;

  sha3_chi_inv #(.LANE_W(LW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  sha3_chi_inv_row u_row_chk (
    .row_i (row_in),
    .row_o (row_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
    int lane;
    n_total++;
    if (got !== exp) begin
      n_bad++;
      lane = 0;
      for (int i = 24; i >= 0; i--) begin
        if (got[i*LW +: LW] !== exp[i*LW +: LW]) lane = i;
      end
      $display("FAIL %s: lane %0d got=%h expected=%h", tag, lane,
               got[lane*LW +: LW], exp[lane*LW +: LW]);
    end
  endtask

  function automatic logic [4:0] ref_chi5(input logic [4:0] a);
    logic [4:0] r;
    r[0] = a[0] ^ (~a[1] & a[2]);
    r[1] = a[1] ^ (~a[2] & a[3]);
    r[2] = a[2] ^ (~a[3] & a[4]);
    r[3] = a[3] ^ (~a[4] & a[0]);
    r[4] = a[4] ^ (~a[0] & a[1]);
    return r;
  endfunction

  function automatic logic [SW-1:0] ref_chi(input logic [SW-1:0] a);
    logic [SW-1:0] o;
    logic [4:0]    row;
    logic [4:0]    res;
    o = '0;
    for (int y = 0; y < 5; y++) begin
      for (int z = 0; z < LW; z++) begin
        for (int x = 0; x < 5; x++) row[x] = a[(x*5+y)*LW + z];
        res = ref_chi5(row);
        for (int x = 0; x < 5; x++) o[(x*5+y)*LW + z] = res[x];
      end
    end
    return o;
  endfunction

  task automatic run_job(input logic [SW-1:0] s, output logic [SW-1:0] res, output int lat);
    int k;
    @(negedge clk);
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("in_ready_before_accept", SW'(in_ready), SW'(1));
    in_valid = 1'b1;
    in_state = s;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    res = out_state;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  logic [SW-1:0] s9, e9, ones, st, res;
  int            lat, cnt;
  logic          seen;

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_state  = '0;
    out_ready = 1'b0;
    row_in    = '0;
    ones      = '1;
    s9        = '0;
    e9        = '0;
    for (int y = 0; y < 5; y++) begin
      s9[(0*5+y)*LW +: LW] = '1;
      s9[(3*5+y)*LW +: LW] = '1;
      e9[(0*5+y)*LW +: LW] = '1;
    end

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", SW'(out_valid), SW'(0));
    check("rst_busy", SW'(busy), SW'(0));
    check("rst_buffer", out_state, '0);
    @(negedge clk) reset = 1'b1;
    #1 check("rst_in_ready", SW'(in_ready), SW'(1));

    // Abort in the middle of RUN, at plane 2.
    @(negedge clk);
    in_valid = 1'b1;
    in_state = ones;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("midrun_busy", SW'(busy), SW'(1));
    reset = 1'b0;
    #1;
    check("abort_out_valid", SW'(out_valid), SW'(0));
    check("abort_busy", SW'(busy), SW'(0));
    check("abort_buffer", out_state, '0);
    @(negedge clk) reset = 1'b1;
    #1 check("abort_in_ready", SW'(in_ready), SW'(1));
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1 if (out_valid) seen = 1'b1;
    end
    check("abort_no_output", SW'(seen), SW'(0));

    run_job('0, res, lat);
    check("zero_result", res, '0);
    check("zero_latency", SW'(lat), SW'(5));

    run_job(s9, res, lat);
    check("row9_result", res, e9);
    check("row9_latency", SW'(lat), SW'(5));

    run_job(ones, res, lat);
    check("ones_result", res, ones);

    for (int n = 0; n < 200; n++) begin
      for (int w = 0; w < SW / 32; w++) st[w*32 +: 32] = $urandom;
      run_job(st, res, lat);
      check("roundtrip", ref_chi(res), st);
    end

    for (int a = 0; a < 32; a++) begin
      row_in = ref_chi5(5'(a));
      #1 check("row_table", SW'(row_out), SW'(a));
    end

    // Backpressure in DONE with a competing input.
    @(negedge clk);
    in_valid = 1'b1;
    in_state = s9;
    @(posedge clk);
    #1 cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(posedge clk);
      #1 cnt++;
    end
    in_state = ones;
    for (int i = 0; i < 10; i++) begin
      check("bp_out_state", out_state, e9);
      check("bp_in_ready", SW'(in_ready), SW'(0));
      check("bp_out_valid", SW'(out_valid), SW'(1));
      @(posedge clk);
      #1;
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hs_out_valid_low", SW'(out_valid), SW'(0));
    check("hs_idle", SW'(busy), SW'(0));
    check("hs_in_ready", SW'(in_ready), SW'(1));
    @(posedge clk);
    #1 check("next_accept", SW'(busy), SW'(1));
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    check("b2b_latency", SW'(lat), SW'(5));
    check("b2b_result", out_state, ones);
    @(posedge clk);
    #1 cnt = 1;
    while (!out_valid && cnt < 30) begin
      @(posedge clk);
      #1 cnt++;
    end
    check("b2b_period", SW'(cnt), SW'(7));
    @(negedge clk) in_valid = 1'b0;
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
